// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps the duty-cycle input of a PWM generator toward a
// requested target. It takes a programmable step after a programmable number
// of PWM periods. Duty changes land only on the edge that closes the last
// cycle of a PWM period, so every PWM period runs with a single duty value.
module pwm_ramp_ctrl #(
  parameter int RESOLUTION = 4,
  parameter int HOLD_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [RESOLUTION-1:0] i_target_duty,
  input  logic [RESOLUTION-1:0] i_step,
  input  logic [HOLD_WIDTH-1:0] i_hold_periods,
  input  logic                  i_abort,
  output logic [RESOLUTION-1:0] o_duty_cycle,
  output logic                  o_period_start,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  localparam logic [RESOLUTION-1:0] PHASE_LAST = {RESOLUTION{1'b1}};
  localparam logic [RESOLUTION-1:0] DUTY_ONE   = RESOLUTION'(1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE   = HOLD_WIDTH'(1);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [RESOLUTION-1:0]   phase_r;
  logic [RESOLUTION-1:0]   duty_r;
  logic [RESOLUTION-1:0]   duty_next_s;
  logic [RESOLUTION-1:0]   target_r;
  logic [RESOLUTION-1:0]   target_next_s;
  logic [RESOLUTION-1:0]   step_r;
  logic [RESOLUTION-1:0]   step_next_s;
  logic [HOLD_WIDTH-1:0]   hold_r;
  logic [HOLD_WIDTH-1:0]   hold_next_s;
  logic [HOLD_WIDTH-1:0]   hold_cnt_r;
  logic [HOLD_WIDTH-1:0]   hold_cnt_next_s;
  logic [HOLD_WIDTH:0]     hold_cnt_inc_s;
  logic [RESOLUTION-1:0]   stepped_duty_s;
  logic                    done_r;
  logic                    done_next_s;
  logic                    boundary_s;

  // One ramp step toward the target, saturating at the target. The extra
  // bit catches both the carry going up and the borrow going down, so the
  // duty can neither overshoot nor wrap.
  function automatic logic [RESOLUTION-1:0] ramp_step(
    input logic [RESOLUTION-1:0] duty,
    input logic [RESOLUTION-1:0] target,
    input logic [RESOLUTION-1:0] step
  );
    logic [RESOLUTION:0] sum;
    logic [RESOLUTION:0] diff;
    logic [RESOLUTION-1:0] result;
    sum  = {1'b0, duty} + {1'b0, step};
    diff = {1'b0, duty} - {1'b0, step};
    if (target > duty) begin
      if (sum >= {1'b0, target}) begin
        result = target;
      end else begin
        result = sum[RESOLUTION-1:0];
      end
    end else begin
      if (diff[RESOLUTION] || (diff[RESOLUTION-1:0] <= target)) begin
        result = target;
      end else begin
        result = diff[RESOLUTION-1:0];
      end
    end
    return result;
  endfunction

  assign boundary_s     = (phase_r == PHASE_LAST);
  assign o_period_start = boundary_s;
  assign o_req_ready    = (state_r == ST_IDLE);
  assign o_busy         = (state_r == ST_RAMP);
  assign o_duty_cycle   = duty_r;
  assign o_done         = done_r;

  assign hold_cnt_inc_s = {1'b0, hold_cnt_r} + (HOLD_WIDTH + 1)'(1);
  assign stepped_duty_s = ramp_step(duty_r, target_r, step_r);

  // Free-running phase counter kept in lockstep with the PWM period counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_r <= {RESOLUTION{1'b0}};
    end else begin
      phase_r <= phase_r + DUTY_ONE;
    end
  end

  // Next-state logic: accept requests, count boundaries, step the duty, abort.
  always_comb begin
    state_next_s    = state_r;
    duty_next_s     = duty_r;
    target_next_s   = target_r;
    step_next_s     = step_r;
    hold_next_s     = hold_r;
    hold_cnt_next_s = hold_cnt_r;
    done_next_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_req_valid) begin
          target_next_s   = i_target_duty;
          step_next_s     = (i_step == {RESOLUTION{1'b0}}) ? DUTY_ONE : i_step;
          hold_next_s     = (i_hold_periods == {HOLD_WIDTH{1'b0}}) ? HOLD_ONE : i_hold_periods;
          hold_cnt_next_s = {HOLD_WIDTH{1'b0}};
          if (i_target_duty == duty_r) begin
            done_next_s = 1'b1;
          end else begin
            state_next_s = ST_RAMP;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (i_abort) begin
          state_next_s    = ST_IDLE;
          hold_cnt_next_s = {HOLD_WIDTH{1'b0}};
        end else if (boundary_s) begin
          if (hold_cnt_inc_s == {1'b0, hold_r}) begin
            duty_next_s     = stepped_duty_s;
            hold_cnt_next_s = {HOLD_WIDTH{1'b0}};
            if (stepped_duty_s == target_r) begin
              state_next_s = ST_IDLE;
              done_next_s  = 1'b1;
            end else begin
              state_next_s = ST_RAMP;
            end
          end else begin
            hold_cnt_next_s = hold_cnt_inc_s[HOLD_WIDTH-1:0];
          end
        end else begin
          state_next_s = ST_RAMP;
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        hold_cnt_next_s = {HOLD_WIDTH{1'b0}};
      end
    endcase
  end

  // Registers for the FSM, the latched request and the duty/done outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      duty_r     <= {RESOLUTION{1'b0}};
      target_r   <= {RESOLUTION{1'b0}};
      step_r     <= DUTY_ONE;
      hold_r     <= HOLD_ONE;
      hold_cnt_r <= {HOLD_WIDTH{1'b0}};
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      duty_r     <= duty_next_s;
      target_r   <= target_next_s;
      step_r     <= step_next_s;
      hold_r     <= hold_next_s;
      hold_cnt_r <= hold_cnt_next_s;
      done_r     <= done_next_s;
    end
  end

endmodule
